// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit holding the architectural HI/LO
// registers.
// Multiply uses radix-2 shift-add and divide uses restoring division. Both
// produce one bit per cycle, and an operation takes DATA_W cycles.
// Signed operations run on the operand magnitudes; the signs are fixed at commit.
// Optional feature: define HILO_OVERWRITE_CHECK_EN to flag HI/LO results that
// are overwritten before MFHI/MFLO reads them.
module hilo_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic              mfhi_i,
  input  logic              mflo_i,
  output logic [DATA_W-1:0] HI_o,
  output logic [DATA_W-1:0] LO_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              Error_DivZero_o,
  output logic              Error_Overwrite_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   acc_q, wrk_q, opb_q;   // upper half, lower half, multiplicand/divisor
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                neg_res_q, neg_rem_q;
  logic                done_q, dz_q;

  // Issue decode. op_i[1] selects divide and op_i[0] selects unsigned.
  logic              issue, is_div, is_sgn, divzero, last;
  logic              rs_neg, rt_neg;
  logic [DATA_W-1:0] abs_a, abs_b;

  assign issue   = start_i && (state_q == S_IDLE);
  assign is_div  = op_i[1];
  assign is_sgn  = ~op_i[0];
  assign divzero = issue && is_div && (RTdata_i == '0);
  assign last    = (cnt_q == CNT_W'(DATA_W - 1));
  assign rs_neg  = is_sgn & RSdata_i[DATA_W-1];
  assign rt_neg  = is_sgn & RTdata_i[DATA_W-1];
  assign abs_a   = rs_neg ? -RSdata_i : RSdata_i;
  assign abs_b   = rt_neg ? -RTdata_i : RTdata_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a divide by zero never leaves IDLE; the last iteration returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (issue && !divzero) state_d = is_div ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (last) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  // One iteration. Multiply adds the multiplicand into the upper half when the
  // current multiplier bit is set, then shifts {carry, acc, wrk} right. Divide
  // shifts the next dividend bit into the partial remainder and subtracts the
  // divisor, keeping the difference if it did not go negative.
  logic [DATA_W:0]     mul_sum, div_sh, div_tr;
  logic [DATA_W-1:0]   acc_n, wrk_n;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, hi_cm, lo_cm;

  always_comb begin
    mul_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : '0);
    div_sh  = {acc_q, wrk_q[DATA_W-1]};
    div_tr  = div_sh - {1'b0, opb_q};
    if (state_q == S_DIV) begin
      acc_n = div_tr[DATA_W] ? div_sh[DATA_W-1:0] : div_tr[DATA_W-1:0];
      wrk_n = {wrk_q[DATA_W-2:0], ~div_tr[DATA_W]};
    end else begin
      acc_n = mul_sum[DATA_W:1];
      wrk_n = {mul_sum[0], wrk_q[DATA_W-1:1]};
    end
    // Sign fix-up. The quotient truncates toward zero and the remainder
    // follows the dividend. The most negative value divided by -1 wraps.
    prod     = {acc_n, wrk_n};
    prod_fix = neg_res_q ? -prod : prod;
    quo_fix  = neg_res_q ? -wrk_n : wrk_n;
    rem_fix  = neg_rem_q ? -acc_n : acc_n;
    if (state_q == S_DIV) begin
      hi_cm = rem_fix;
      lo_cm = quo_fix;
    end else begin
      hi_cm = prod_fix[2*DATA_W-1:DATA_W];
      lo_cm = prod_fix[DATA_W-1:0];
    end
  end

  // Datapath: latch operands on issue, iterate while busy, commit HI/LO on the last iteration
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      wrk_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      if (issue) begin
        cnt_q     <= '0;
        acc_q     <= '0;
        wrk_q     <= abs_a;
        opb_q     <= abs_b;
        neg_res_q <= rs_neg ^ rt_neg;
        neg_rem_q <= rs_neg;
        dz_q      <= divzero;
      end else if (busy_o) begin
        cnt_q <= cnt_q + CNT_W'(1);
        acc_q <= acc_n;
        wrk_q <= wrk_n;
        if (last) begin
          hi_q   <= hi_cm;
          lo_q   <= lo_cm;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign HI_o            = hi_q;
  assign LO_o            = lo_q;
  assign done_o          = done_q;
  assign Error_DivZero_o = dz_q;

`ifdef HILO_OVERWRITE_CHECK_EN
  logic unread_q, ovw_q, rd;

  // A read that arrives in the same cycle as an issue consumes the old
  // result first, so that issue raises no error.
  assign rd = (mfhi_i || mflo_i) && !busy_o;

  // Unread flag: set on commit, cleared by an idle-time read; flag an issue that would clobber it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      unread_q <= 1'b0;
      ovw_q    <= 1'b0;
    end else begin
      ovw_q <= issue && unread_q && !rd;
      if (busy_o && last) unread_q <= 1'b1;
      else if (rd)        unread_q <= 1'b0;
    end
  end

  assign Error_Overwrite_o = ovw_q;
`else
  logic unused_rd;
  assign unused_rd         = mfhi_i ^ mflo_i;
  assign Error_Overwrite_o = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv.
// Stimulus pushes each expected HI/LO commit or divide-by-zero event into a
// queue. A monitor compares every done_o or Error_DivZero_o against the head.
module tb_hilo_muldiv;
`ifdef HILO_OVERWRITE_CHECK_EN
  localparam logic OVW_EN = 1'b1;
`else
  localparam logic OVW_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, mfhi_i, mflo_i;
  logic [1:0]  op_i;
  logic [31:0] RSdata_i, RTdata_i, HI_o, LO_o;
  logic        busy_o, done_o, Error_DivZero_o, Error_Overwrite_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb_q[$];

  hilo_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .mfhi_i(mfhi_i), .mflo_i(mflo_i),
    .HI_o(HI_o), .LO_o(LO_o), .busy_o(busy_o), .done_o(done_o),
    .Error_DivZero_o(Error_DivZero_o), .Error_Overwrite_o(Error_Overwrite_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    if (!rst_i && (done_o || Error_DivZero_o)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: done=%b dz=%b HI=%h LO=%h", done_o, Error_DivZero_o, HI_o, LO_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (Error_DivZero_o !== e.dz || done_o !== !e.dz || HI_o !== e.hi || LO_o !== e.lo) begin
          errors++;
          $display("FAIL result: got dz=%b done=%b HI=%h LO=%h expected dz=%b HI=%h LO=%h",
                   Error_DivZero_o, done_o, HI_o, LO_o, e.dz, e.hi, e.lo);
        end
      end
    end
  end

  // Push the expectation, then issue; returns at the negedge after the issue edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rd, input logic dz, input logic [31:0] eh,
                       input logic [31:0] el, input logic eovw);
    exp_t e;
    e.dz = dz; e.hi = eh; e.lo = el;
    sb_q.push_back(e);
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; RSdata_i = a; RTdata_i = b; mflo_i = rd;
    @(negedge clk_i);
    start_i = 1'b0; mflo_i = 1'b0;
    chk("overwrite_pulse", {31'd0, Error_Overwrite_o}, {31'd0, eovw});
    chk("divzero_pulse", {31'd0, Error_DivZero_o}, {31'd0, dz});
    chk("busy_after_issue", {31'd0, busy_o}, {31'd0, !dz});
  endtask

  // Count the remaining busy cycles, then check the done pulse and its width
  task automatic wait_done(input int exp_busy);
    int n = 0;
    while (busy_o && n < 40) begin
      n++;
      @(negedge clk_i);
    end
    chk("busy_cycles", n, exp_busy);
    chk("done_pulse", {31'd0, done_o}, 32'd1);
    @(negedge clk_i);
    chk("done_width", {31'd0, done_o}, 32'd0);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic eovw);
    issue(op, a, b, 1'b0, 1'b0, eh, el, eovw);
    wait_done(32);
  endtask

  task automatic read_lo();
    @(negedge clk_i); mflo_i = 1'b1;
    @(negedge clk_i); mflo_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; RSdata_i = '0; RTdata_i = '0;
    mfhi_i = 1'b0; mflo_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_HI", HI_o, 32'd0);
    chk("rst_LO", LO_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_dz", {31'd0, Error_DivZero_o}, 32'd0);
    chk("rst_ovw", {31'd0, Error_Overwrite_o}, 32'd0);

    run(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);       // -3*5
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, OVW_EN);
    run(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, OVW_EN);     // -7/2
    run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, OVW_EN);
    run(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, OVW_EN);

    // Divide by zero: single pulse, never busy, HI/LO keep 2/14
    issue(2'b11, 32'd10, 32'd0, 1'b0, 1'b1, 32'd2, 32'd14, OVW_EN);
    @(negedge clk_i);
    chk("dz_width", {31'd0, Error_DivZero_o}, 32'd0);
    chk("dz_busy", {31'd0, busy_o}, 32'd0);
    chk("dz_HI", HI_o, 32'd2);
    chk("dz_LO", LO_o, 32'd14);

    // Overwrite hazard: read, 2*3, then 4*5 without read, then read before 6*7
    read_lo();
    run(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    run(2'b00, 32'd4, 32'd5, 32'd0, 32'd20, OVW_EN);
    read_lo();
    run(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // Read in the same cycle as issue wins; start during busy cycle 5 is ignored
    issue(2'b00, 32'd7, 32'd9, 1'b1, 1'b0, 32'd0, 32'd63, 1'b0);
    repeat (4) @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; RSdata_i = 32'd100; RTdata_i = 32'd100;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(27);

    // Reset at busy cycle 10 aborts: no done, HI/LO cleared
    sb_q.push_back('{dz: 1'b0, hi: 32'd0, lo: 32'd63});
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; RSdata_i = 32'd7; RTdata_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    void'(sb_q.pop_back());
    chk("abort_busy_start", {31'd0, busy_o}, 32'd1);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_HI", HI_o, 32'd0);
    chk("abort_LO", LO_o, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    repeat (40) @(negedge clk_i);

    // After reset the unread flag is clear: -1 * -1
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0);

    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
